bin_pixel_pack_ctrl: RTL

//  Sequences one frame capture of thresholded 1-bit pixels from the RAW2RGB path into SDRAM write FIFO port 1.

---
 rtl/bin_pixel_pack_if.sv | 26 ++
 rtl/bin_pixel_pack_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bin_pixel_pack_if.sv
// rtl/bin_pixel_pack_if.sv - capture request, camera pixel stream and SDRAM write port bundle
interface bin_pixel_pack_if #(
    parameter int PACK_W = 16,
    parameter int WCNT_W = 15
);
    logic              iCapture_Req;
    logic              iFVAL;
    logic              iPix;
    logic              iPix_Val;
    logic [PACK_W-1:0] oWr_Data;
    logic              oWr_En;
    logic [WCNT_W-1:0] oWord_Cnt;
    logic              oBusy;
    logic              oDone;
    logic              oOverrun;

    modport master (
        output iCapture_Req, iFVAL, iPix, iPix_Val,
        input  oWr_Data, oWr_En, oWord_Cnt, oBusy, oDone, oOverrun
    );

    modport slave (
        input  iCapture_Req, iFVAL, iPix, iPix_Val,
        output oWr_Data, oWr_En, oWord_Cnt, oBusy, oDone, oOverrun
    );
endinterface

// File: rtl/bin_pixel_pack_ctrl.sv
// rtl/bin_pixel_pack_ctrl.sv - single-frame capture of 1-bit pixels packed into SDRAM write words
module bin_pixel_pack_ctrl #(
    parameter int PACK_W    = 16,
    parameter int FRAME_PIX = 307200,
    parameter int WCNT_W    = 15
) (
    input logic               CCD_PIXCLK,
    input logic               DLY_RST_1,
    bin_pixel_pack_if.slave   bus
);
    localparam int                BC_W   = $clog2(PACK_W);
    localparam logic [BC_W-1:0]   BC_MAX = BC_W'(PACK_W - 1);
    localparam logic [WCNT_W-1:0] LIMIT  = WCNT_W'(FRAME_PIX / PACK_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_req_s1;
    logic              r_req_s2;
    logic              r_fval_d;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [PACK_W-1:0] r_word;
    logic [PACK_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic [WCNT_W-1:0] r_word_cnt;
    logic              r_overrun;

    logic              w_req_s;
    logic              w_fval_rise;
    logic              w_fval_fall;
    logic              w_pix_in;
    logic              w_pix_acc;
    logic              w_pix_drop;
    logic              w_word_done;
    logic              w_flush;
    logic [PACK_W-1:0] w_word_next;

    assign w_req_s     = r_req_s2;
    assign w_fval_rise = bus.iFVAL & ~r_fval_d;
    assign w_fval_fall = ~bus.iFVAL & r_fval_d;

    // The rise cycle already carries the first pixel of the frame.
    assign w_pix_in    = w_req_s && bus.iPix_Val && bus.iFVAL &&
                         ((r_state == S_CAPTURE) || (r_state == S_WAIT_SOF && w_fval_rise));
    assign w_pix_acc   = w_pix_in && (r_word_cnt != LIMIT);
    assign w_pix_drop  = w_pix_in && (r_word_cnt == LIMIT);
    assign w_word_done = w_pix_acc && (r_bit_cnt == BC_MAX);
    assign w_flush     = (r_state == S_FLUSH) && w_req_s;

    always_comb begin
        w_word_next            = r_word;
        w_word_next[r_bit_cnt] = bus.iPix;
    end

    always_ff @(posedge CCD_PIXCLK or negedge DLY_RST_1) begin
        if (!DLY_RST_1) begin
            r_state  <= S_IDLE;
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_fval_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_req_s1 <= bus.iCapture_Req;
            r_req_s2 <= r_req_s1;
            r_fval_d <= bus.iFVAL;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_req_s) w_state_nxt = S_WAIT_SOF;
            S_WAIT_SOF: begin
                if (!w_req_s)         w_state_nxt = S_IDLE;
                else if (w_fval_rise) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!w_req_s)         w_state_nxt = S_IDLE;
                else if (w_fval_fall) w_state_nxt = S_FLUSH;
            end
            S_FLUSH:    w_state_nxt = w_req_s ? S_DONE : S_IDLE;
            S_DONE:     if (!w_req_s) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CCD_PIXCLK or negedge DLY_RST_1) begin
        if (!DLY_RST_1) begin
            r_bit_cnt  <= '0;
            r_word     <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_word_cnt <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state == S_IDLE && w_req_s) begin
                r_bit_cnt  <= '0;
                r_word     <= '0;
                r_word_cnt <= '0;
                r_overrun  <= 1'b0;
            end
            if (w_pix_acc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_word_done) begin
                    r_word     <= '0;
                    r_wr_data  <= w_word_next;
                    r_wr_en    <= 1'b1;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end else begin
                    r_word <= w_word_next;
                end
            end
            if (w_pix_drop)
                r_overrun <= 1'b1;
            // Any leftover bits or a missing full word means the frame was not FRAME_PIX long.
            if (w_flush) begin
                if (r_bit_cnt != '0) begin
                    r_wr_data  <= r_word;
                    r_wr_en    <= 1'b1;
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_overrun  <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_word     <= '0;
                end
                if (r_word_cnt != LIMIT)
                    r_overrun <= 1'b1;
            end
        end
    end

    assign bus.oWr_Data  = r_wr_data;
    assign bus.oWr_En    = r_wr_en;
    assign bus.oWord_Cnt = r_word_cnt;
    assign bus.oOverrun  = r_overrun;
    assign bus.oBusy     = (r_state == S_WAIT_SOF) || (r_state == S_CAPTURE) || (r_state == S_FLUSH);
    assign bus.oDone     = (r_state == S_DONE);
endmodule
